count_sequencer: RTL and testbench
==================================

# count_sequencer

Single-clock controller that drives the 8-bit LED count in an automatic "bounce" pattern. It counts up from a low bound to a high bound, dwells, counts down to the low bound, dwells, and repeats. The step rate comes from an internal enable-based prescaler with four selectable speeds, so no divided or multiplexed clocks are used. It sits between the board switches/buttons and the LED bank and replaces free-running counting with a sequenced, start/stop-controlled pattern.

## Interface
- BASE_DIV, 4: clock cycles per step at speed 0; must be ≥ 2.
- HOLD_TICKS, 2: dwell length at each bound, in step ticks; must be ≥ 1.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begins a run from IDLE.
- stop  in  1  level; aborts a run and returns to IDLE.
- speed  in  2  rate select; step period P = BASE_DIV << speed cycles.
- lo  in  8  low bound; sampled only on an accepted start.
- hi  in  8  high bound; sampled only on an accepted start.
- count  out  8  current pattern value, intended for the LEDs.
- ud  out  1  1 = rising phase (IDLE, UP, HOLD_LO); 0 = falling phase (HOLD_HI, DOWN).
- busy  out  1  1 in every state except IDLE.
- step  out  1  one-cycle pulse, registered; high on the cycle after count changes by ±1.
- laps  out  8  number of completed up/down cycles; wraps 255 → 0.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- Reset values: state=IDLE, count=0, ud=1, busy=0, step=0, laps=0, cfg_err=0, prescaler=0, hold counter=0.
- Prescaler:
  - Counts 0..P−1 in every state except IDLE.
  - tick = (prescaler == P−1); the prescaler wraps to 0 on tick.
  - speed is registered into speed_q. If speed != speed_q, the prescaler clears to 0 that cycle and no tick fires.
  - In IDLE, the prescaler is held at 0.
- IDLE, with start=1 and stop=0:
  - If lo < hi: latch lo/hi, set count=lo, go to UP, clear the prescaler.
  - Otherwise: pulse cfg_err; state and count unchanged.
- UP: on each tick, count+1. A tick that makes count == hi_q moves to HOLD_HI.
- HOLD_HI: the hold counter counts ticks. On tick number HOLD_TICKS, go to DOWN and clear the hold counter. count is unchanged.
- DOWN: on each tick, count−1. A tick that makes count == lo_q moves to HOLD_LO.
- HOLD_LO: same dwell rule as HOLD_HI. On exit to UP, laps increments.
- stop=1 in any non-IDLE state: go to IDLE on the next edge.
  - count and laps retain their values.
  - The hold counter and prescaler clear.
- stop has priority over start. start while busy is ignored.
- count never leaves [lo_q, hi_q] while busy. No wrap past 0 or 255 is possible.
- Asynchronous reset mid-run forces all reset values immediately, without waiting for a clock edge.

## Timing
- Accepted start at edge k:
  - busy=1 and count=lo, both visible after edge k.
  - First increment occurs at edge k+P.
- Each step in UP or DOWN takes exactly P cycles when speed is stable.
- hi is held for (HOLD_TICKS+1)·P cycles. lo is held for the same time within a run.
- ud changes on the edge that enters HOLD_HI (→0) or HOLD_LO (→1).
- cfg_err goes high the cycle after the rejected start edge and stays high exactly 1 cycle.
- A speed change delays the next tick by P_new cycles, counted from the first edge where speed_q is updated.

## Test plan
- Bounce sequence, BASE_DIV=4, HOLD_TICKS=2, speed=0 (P=4), lo=3, hi=6, start at edge 0:
  - count = 3@0, 4@4, 5@8, 6@12 (ud→0 at 12), 5@24, 4@28, 3@32 (ud→1).
  - UP re-entered at edge 40 with laps=1; count=4@44.
- Bad config: lo=9, hi=9, start:
  - cfg_err high exactly 1 cycle.
  - busy stays 0; count unchanged.
  - Repeat with lo=10, hi=2: same response.
- Stop mid-run: stop while count=5 in UP:
  - Next edge: busy=0, count=5, ud=1.
  - Later, start and stop asserted together in IDLE: state stays IDLE.
- Speed change: speed 0 → 2 mid-period:
  - No step for 16 cycles after speed_q updates.
  - Subsequent steps every 16 cycles.
- Asynchronous reset mid-run: assert reset between clock edges during DOWN:
  - count=0, busy=0, laps=0, ud=1 immediately, before the next edge.
  - Normal start works after reset is released.
- laps wrap: lo=0, hi=1, run 256 laps → laps wraps from 255 to 0.

Source files
------------

// File: rtl/count_sequencer_if.sv
// ----------------------------------------------------------------------------
// count_sequencer_if
// Groups the control inputs and pattern outputs of count_sequencer.
//
// Signalling: there is no valid/ready handshake on this interface. Every
// control input is a level. start is acted on only while the sequencer is
// idle, stop wins over start, and lo/hi are sampled only on an accepted start.
// step and cfg_err are single-cycle registered pulses. All other outputs are
// registered levels, or decodes of registered state.
//
// Signals
//   start, stop   controller -> sequencer   run control levels
//   speed[1:0]    controller -> sequencer   step period = BASE_DIV << speed
//   lo, hi [7:0]  controller -> sequencer   bounce bounds
//   count [7:0]   sequencer -> controller   current pattern value (LEDs)
//   ud            sequencer -> controller   1 = rising phase, 0 = falling
//   busy          sequencer -> controller   not idle
//   step          sequencer -> controller   pulse after each +/-1 change
//   laps  [7:0]   sequencer -> controller   completed up/down cycles, wraps
//   cfg_err       sequencer -> controller   pulse on a rejected start
//   state [2:0]   sequencer -> controller   FSM state, for debug/observation
// ----------------------------------------------------------------------------
interface count_sequencer_if;
    logic       start;
    logic       stop;
    logic [1:0] speed;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] count;
    logic       ud;
    logic       busy;
    logic       step;
    logic [7:0] laps;
    logic       cfg_err;
    logic [2:0] state;

    modport master (
        output start, stop, speed, lo, hi,
        input  count, ud, busy, step, laps, cfg_err, state
    );

    modport slave (
        input  start, stop, speed, lo, hi,
        output count, ud, busy, step, laps, cfg_err, state
    );
endinterface

// File: rtl/count_sequencer.sv
// ----------------------------------------------------------------------------
// count_sequencer
// Drives an 8-bit LED count in a bounce pattern: it counts up from lo to hi,
// dwells, counts down to lo, dwells, and repeats. The step rate comes from an
// enable-style prescaler, so the whole block runs on clk alone.
//
// Parameters
//   BASE_DIV    clock cycles per step at speed 0 (>= 2)
//   HOLD_TICKS  dwell length at each bound, in step ticks (>= 1)
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   bus         count_sequencer_if.slave (control in, pattern/status out)
// ----------------------------------------------------------------------------
module count_sequencer #(
    parameter int BASE_DIV   = 4,
    parameter int HOLD_TICKS = 2
) (
    input  logic                clk,
    input  logic                reset,
    count_sequencer_if.slave    bus
);

    // The prescaler must reach BASE_DIV*8 - 1 (speed 3).
    localparam int PW = $clog2(BASE_DIV * 8);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_UP      = 3'd1;
    localparam logic [2:0] S_HOLD_HI = 3'd2;
    localparam logic [2:0] S_DOWN    = 3'd3;
    localparam logic [2:0] S_HOLD_LO = 3'd4;

    logic [2:0]    state;
    logic [1:0]    speed_q;
    logic [PW-1:0] pre;
    logic [PW-1:0] period_m1;
    logic [HW-1:0] hold;
    logic [7:0]    lo_q;
    logic [7:0]    hi_q;
    logic [7:0]    count;
    logic [7:0]    laps;
    logic          step;
    logic          cfg_err;

    logic          speed_chg;
    logic          tick;
    logic          start_req;
    logic          start_ok;
    logic          hold_done;
    logic          abort;

    always_comb begin
        period_m1 = PW'((BASE_DIV << speed_q) - 1);
        speed_chg = (bus.speed != speed_q);
        // A speed change suppresses the tick so the new period starts cleanly.
        tick      = (state != S_IDLE) && !speed_chg && (pre == period_m1);
        start_req = (state == S_IDLE) && bus.start && !bus.stop;
        start_ok  = start_req && (bus.lo < bus.hi);
        hold_done = (hold == HW'(HOLD_TICKS - 1));
        abort     = (state != S_IDLE) && bus.stop;
    end

    // Prescaler. It is held at zero while idle, so it also reads zero on the
    // cycle that follows an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_q <= 2'd0;
            pre     <= '0;
        end else begin
            speed_q <= bus.speed;
            if (state == S_IDLE || speed_chg || tick || abort)
                pre <= '0;
            else
                pre <= pre + PW'(1);
        end
    end

    // Sequencer FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 8'd0;
            laps    <= 8'd0;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
            hold    <= '0;
            step    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            step    <= 1'b0;
            cfg_err <= start_req && !start_ok;
            if (abort) begin
                // count and laps are left as they are, so the LEDs freeze.
                state <= S_IDLE;
                hold  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            lo_q  <= bus.lo;
                            hi_q  <= bus.hi;
                            count <= bus.lo;
                            state <= S_UP;
                        end
                    end
                    S_UP: begin
                        if (tick) begin
                            count <= count + 8'd1;
                            step  <= 1'b1;
                            if (count + 8'd1 == hi_q)
                                state <= S_HOLD_HI;
                        end
                    end
                    S_HOLD_HI: begin
                        if (tick) begin
                            if (hold_done) begin
                                hold  <= '0;
                                state <= S_DOWN;
                            end else begin
                                hold <= hold + HW'(1);
                            end
                        end
                    end
                    S_DOWN: begin
                        if (tick) begin
                            count <= count - 8'd1;
                            step  <= 1'b1;
                            if (count - 8'd1 == lo_q)
                                state <= S_HOLD_LO;
                        end
                    end
                    S_HOLD_LO: begin
                        if (tick) begin
                            if (hold_done) begin
                                hold  <= '0;
                                laps  <= laps + 8'd1;
                                state <= S_UP;
                            end else begin
                                hold <= hold + HW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        hold  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.count   = count;
    assign bus.ud      = (state != S_HOLD_HI) && (state != S_DOWN);
    assign bus.busy    = (state != S_IDLE);
    assign bus.step    = step;
    assign bus.laps    = laps;
    assign bus.cfg_err = cfg_err;
    assign bus.state   = state;

endmodule

// File: tb/tb_count_sequencer.sv
// ----------------------------------------------------------------------------
// tb_count_sequencer
// Self-checking bench for count_sequencer. The reference model works out the
// whole bounce trajectory with arithmetic on the tick index: lap position,
// lap count, phase and step pulses.
// ----------------------------------------------------------------------------
module tb_count_sequencer;
    localparam int BASE_DIV = 4;
    localparam int HOLD     = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_sequencer_if bus ();

    count_sequencer #(.BASE_DIV(BASE_DIV), .HOLD_TICKS(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_laps  = 0;
    int exp_count = 0;

    // Observed {count, ud, busy, step, laps}.
    function automatic logic [18:0] obs();
        return {bus.count, bus.ud, bus.busy, bus.step, bus.laps};
    endfunction

    // Reference model. t is the number of cycles since the accepted-start
    // edge, and the speed is assumed stable. It returns the expected
    // {count, ud, busy, step, laps}.
    function automatic logic [18:0] model(input int t, input int lo, input int hi,
                                          input int p, input int base);
        int j, n, l, m, c, u, s, lp;
        j  = t / p;
        n  = hi - lo;
        l  = 2 * n + 2 * HOLD;
        m  = j % l;
        lp = (base + j / l) % 256;
        if (m <= n)                c = lo + m;
        else if (m <= n + HOLD)    c = hi;
        else if (m <= 2*n + HOLD)  c = hi - (m - n - HOLD);
        else                       c = lo;
        u = (m < n || m >= 2*n + HOLD) ? 1 : 0;
        s = (t > 0 && t % p == 0 &&
             ((m >= 1 && m <= n) || (m > n + HOLD && m <= 2*n + HOLD))) ? 1 : 0;
        return {8'(c), 1'(u), 1'b1, 1'(s), 8'(lp)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_laps  = 0;
        exp_count = 0;
    endtask

    // Returns one cycle after the accepted-start edge, i.e. at t = 0.
    task automatic drive_start(input int lo, input int hi, input int spd);
        bus.speed = 2'(spd);
        @(posedge clk); #1;
        bus.lo    = 8'(lo);
        bus.hi    = 8'(hi);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Stops the run and records the values that should be frozen.
    task automatic drive_stop(input logic [18:0] last);
        exp_count = int'(last[18:11]);
        exp_laps  = int'(last[7:0]);
        bus.stop  = 1'b1;
        @(posedge clk); #1;
        bus.stop  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (obs() !== {8'd0, 1'b1, 1'b0, 1'b0, 8'd0} || bus.cfg_err !== 1'b0 || bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h/%b exp=%h/0", obs(), bus.cfg_err, {8'd0, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (obs() !== {8'd0, 1'b1, 1'b0, 1'b0, 8'd0} || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", obs(), {8'd0, 1'b1, 1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_bounce();
        int tt [8] = '{0, 4, 8, 12, 24, 28, 32, 44};
        int cc [8] = '{3, 4, 5, 6, 5, 4, 3, 4};
        logic [18:0] e;
        int base;
        base = exp_laps;
        drive_start(3, 6, 0);
        for (int t = 0; t <= 60; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = model(t, 3, 6, 4, base);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL bounce t=%0d got=%h exp=%h", t, obs(), e);
            end
            for (int k = 0; k < 8; k++) begin
                if (t == tt[k]) begin
                    n_tests++;
                    if (bus.count !== 8'(cc[k])) begin
                        n_fail++;
                        $display("FAIL bounce_point t=%0d count got=%0d exp=%0d", t, bus.count, cc[k]);
                    end
                end
            end
            if (t == 12 || t == 32) begin
                n_tests++;
                if (bus.ud !== (t == 32)) begin
                    n_fail++;
                    $display("FAIL bounce_ud t=%0d got=%b exp=%b", t, bus.ud, (t == 32));
                end
            end
            if (t == 40) begin
                n_tests++;
                if (bus.laps !== 8'(base + 1) || bus.state !== 3'd1) begin
                    n_fail++;
                    $display("FAIL bounce_lap t=40 laps got=%0d exp=%0d", bus.laps, base + 1);
                end
            end
        end
        drive_stop(e);
        n_tests++;
        if (obs() !== {8'(exp_count), 1'b1, 1'b0, 1'b0, 8'(exp_laps)}) begin
            n_fail++;
            $display("FAIL bounce_stop got=%h exp=%h", obs(), {8'(exp_count), 1'b1, 1'b0, 1'b0, 8'(exp_laps)});
        end
    endtask

    task automatic test_bad_config();
        int los [2] = '{9, 10};
        int his [2] = '{9, 2};
        for (int k = 0; k < 2; k++) begin
            bus.lo    = 8'(los[k]);
            bus.hi    = 8'(his[k]);
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            n_tests++;
            if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'(exp_count)) begin
                n_fail++;
                $display("FAIL bad_cfg_pulse k=%0d cfg_err/busy/count got=%b/%b/%0d exp=1/0/%0d",
                         k, bus.cfg_err, bus.busy, bus.count, exp_count);
            end
            @(posedge clk); #1;
            n_tests++;
            if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 8'(exp_count)) begin
                n_fail++;
                $display("FAIL bad_cfg_after k=%0d cfg_err/busy/count got=%b/%b/%0d exp=0/0/%0d",
                         k, bus.cfg_err, bus.busy, bus.count, exp_count);
            end
        end
    endtask

    task automatic test_stop_mid_run();
        logic [18:0] e;
        int base;
        base = exp_laps;
        drive_start(2, 9, 0);
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = model(t, 2, 9, 4, base);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL stop_run t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        n_tests++;
        if ({bus.count, bus.ud, bus.busy, bus.laps} !== {8'd5, 1'b1, 1'b0, 8'(base)}) begin
            n_fail++;
            $display("FAIL stop_freeze count/ud/busy got=%0d/%b/%b exp=5/1/0", bus.count, bus.ud, bus.busy);
        end
        exp_count = 5;
        bus.lo    = 8'd1;
        bus.hi    = 8'd5;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.count !== 8'd5 || bus.cfg_err !== 1'b0 || bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL start_stop_idle busy/count/cfg_err got=%b/%0d/%b exp=0/5/0",
                     bus.busy, bus.count, bus.cfg_err);
        end
    endtask

    task automatic test_speed_change();
        logic [18:0] e;
        int c, s;
        drive_start(0, 200, 0);
        for (int t = 0; t <= 2; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = model(t, 0, 200, 4, exp_laps);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL speed_pre t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        // speed_q picks this up at edge 3, which restarts the 16-cycle period.
        bus.speed = 2'd2;
        for (int t = 3; t <= 3 + 16 * 3 + 4; t++) begin
            @(posedge clk); #1;
            c = (t - 3) / 16;
            s = (t > 3 && (t - 3) % 16 == 0) ? 1 : 0;
            e = {8'(c), 1'b1, 1'b1, 1'(s), 8'(exp_laps)};
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL speed_post t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        drive_stop(e);
    endtask

    task automatic test_random();
        logic [18:0] e;
        int lo, hi, spd, cyc, base;
        for (int r = 0; r < 4; r++) begin
            lo   = $urandom_range(0, 240);
            hi   = lo + $urandom_range(1, 6);
            spd  = $urandom_range(0, 2);
            cyc  = $urandom_range(50, 300);
            base = exp_laps;
            drive_start(lo, hi, spd);
            for (int t = 0; t <= cyc; t++) begin
                if (t > 0) begin @(posedge clk); #1; end
                e = model(t, lo, hi, BASE_DIV << spd, base);
                n_tests++;
                if (obs() !== e) begin
                    n_fail++;
                    $display("FAIL random r=%0d lo=%0d hi=%0d spd=%0d t=%0d got=%h exp=%h",
                             r, lo, hi, spd, t, obs(), e);
                end
            end
            drive_stop(e);
            n_tests++;
            if (obs() !== {8'(exp_count), 1'b1, 1'b0, 1'b0, 8'(exp_laps)}) begin
                n_fail++;
                $display("FAIL random_stop r=%0d got=%h exp=%h", r, obs(),
                         {8'(exp_count), 1'b1, 1'b0, 1'b0, 8'(exp_laps)});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] e;
        int lo, hi, spd, p, n, tgt, base;
        lo   = $urandom_range(0, 100);
        hi   = lo + $urandom_range(2, 5);
        spd  = $urandom_range(0, 1);
        p    = BASE_DIV << spd;
        n    = hi - lo;
        base = exp_laps;
        tgt  = (n + HOLD + 1) * p + 1;
        drive_start(lo, hi, spd);
        for (int t = 0; t <= tgt; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = model(t, lo, hi, p, base);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL areset_run t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        n_tests++;
        if (bus.state !== 3'd3) begin
            n_fail++;
            $display("FAIL areset_in_down state got=%0d exp=3", bus.state);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (obs() !== {8'd0, 1'b1, 1'b0, 1'b0, 8'd0} || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate got=%h exp=%h", obs(), {8'd0, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        exp_laps  = 0;
        exp_count = 0;
        drive_start(5, 8, 0);
        for (int t = 0; t <= 48; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = model(t, 5, 8, 4, 0);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL areset_restart t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        drive_stop(e);
    endtask

    task automatic test_laps_wrap();
        logic [18:0] e;
        apply_reset();
        drive_start(0, 1, 0);
        // lap = 2*1 + 2*HOLD = 6 ticks = 24 cycles
        for (int t = 0; t <= 256 * 24 + 4; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            e = model(t, 0, 1, 4, 0);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL laps_run t=%0d got=%h exp=%h", t, obs(), e);
            end
            if (t == 255 * 24 || t == 256 * 24) begin
                n_tests++;
                if (bus.laps !== ((t == 255 * 24) ? 8'd255 : 8'd0)) begin
                    n_fail++;
                    $display("FAIL laps_wrap t=%0d got=%0d exp=%0d", t, bus.laps,
                             (t == 255 * 24) ? 255 : 0);
                end
            end
        end
        drive_stop(e);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.speed = 2'd0;
        bus.lo    = 8'd0;
        bus.hi    = 8'd0;
        test_reset();
        test_bounce();
        test_bad_config();
        test_stop_mid_run();
        test_speed_change();
        test_random();
        test_async_reset();
        test_laps_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
